seq_tx_1101: RTL and testbench

- Serial frame transmitter and the sending end of the 1101-sync serial link.
- Accepts a parallel word over a valid/ready handshake, emits a fixed sync header (default 1101), then the data bits MSB-first on a 1-bit line.
- An inter-frame gap follows each frame.
- The receiving end runs the team's 1101 Moore detector (det_1101) for frame alignment.

---
 rtl/seq_tx_1101.sv | 121 ++++++++++++
 tb/tb_seq_tx_1101.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_1101.sv
// seq_tx_1101: serial frame transmitter for the 1101-sync link.
// Sends the sync header, then the payload MSB-first, then an idle gap.
module seq_tx_1101 #(
    parameter int                DATA_W     = 8,
    parameter int                SYNC_W     = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 4'b1101,
    parameter int                GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    if ((DATA_W < 1) || (DATA_W > 32)) begin : g_bad_data_w
        $error("seq_tx_1101: DATA_W out of range 1..32");
    end
    if ((SYNC_W < 1) || (SYNC_W > 8)) begin : g_bad_sync_w
        $error("seq_tx_1101: SYNC_W out of range 1..8");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_bad_gap
        $error("seq_tx_1101: GAP_CYCLES out of range 0..15");
    end

    localparam logic [7:0] SYNC_EXT  = 8'(SYNC_PAT);
    localparam logic [4:0] SYNC_LAST = 5'(SYNC_W - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
    localparam logic [4:0] GAP_LAST  =
        (GAP_CYCLES > 0) ? 5'(GAP_CYCLES - 1) : 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    // One down-counter serves as sync index, data count and gap count.
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        frame_q, frame_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shreg_d = tx_data;
                    cnt_d   = SYNC_LAST;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (cnt_q == 5'd0) begin
                    cnt_d   = DATA_LAST;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DATA: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == 5'd0) begin
                    frame_d = frame_q + 8'd1;
                    cnt_d   = GAP_LAST;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            GAP: begin
                if (cnt_q == 5'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tx_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == SYNC) || (state_q == DATA);
        frame_cnt = frame_q;
        out       = 1'b0;
        case (state_q)
            SYNC:    out = SYNC_EXT[cnt_q[2:0]];
            DATA:    out = shreg_q[DATA_W-1];
            default: out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_seq_tx_1101.sv
// tb_seq_tx_1101: vector tables, corner sequences and random traffic
// checked against a queue-of-bits model of the transmitted line.
module tb_seq_tx_1101;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    seq_tx_1101 dut (
        .clk      (clk),
        .rstn     (rstn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic o;
        logic v;
        logic idle;
        logic last;
    } ent_t;

    typedef struct {
        logic [7:0]  d;
        logic [11:0] bits;
    } vec_t;

    ent_t        q[$];
    ent_t        cur;
    int          fcnt;
    int          pass_n;
    int          total_n;
    int          cyc;
    logic [11:0] obs;
    int          obs_n;
    int          acc_cyc[$];
    logic [3:0]  hist;
    logic        det;
    int          det_cnt;
    int          det_pos;
    int          det_base;
    vec_t        vecs[5];

    function automatic ent_t mk(logic o, logic v, logic idle, logic last);
        ent_t e;
        e.o = o;
        e.v = v;
        e.idle = idle;
        e.last = last;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Compare this cycle, drive inputs for the next edge, advance model.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic        o_s;
        logic [11:0] frame;
        chk("out", int'(out), int'(cur.o));
        chk("out_valid", int'(out_valid), int'(cur.v));
        chk("tx_ready", int'(tx_ready), int'(cur.idle));
        chk("busy", int'(busy), int'(!cur.idle));
        chk("frame_cnt", int'(frame_cnt), fcnt);
        if (det) begin
            det_cnt++;
            det_pos = cyc - det_base;
        end
        o_s = out;
        if (out_valid) begin
            obs = {obs[10:0], out};
            obs_n++;
        end
        tx_valid = v;
        tx_data  = d;
        if (cur.last) fcnt = (fcnt + 1) % 256;
        if (cur.idle && v) begin
            acc_cyc.push_back(cyc);
            frame = {4'b1101, d};
            for (int i = 11; i >= 0; i--)
                q.push_back(mk(frame[i], 1'b1, 1'b0, i == 0));
            for (int g = 0; g < 2; g++)
                q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        end
        cur = (q.size() > 0) ? q.pop_front() : mk(0, 0, 1, 0);
        @(posedge clk);
        hist = {hist[2:0], o_s};
        det  = (hist == 4'b1101);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        q.delete();
        cur  = mk(0, 0, 1, 0);
        fcnt = 0;
        tx_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int base;
        pass_n = 0;
        total_n = 0;
        cyc = 0;
        fcnt = 0;
        hist = '0;
        det = 1'b0;
        det_cnt = 0;
        det_pos = -1;
        det_base = 0;
        obs = '0;
        obs_n = 0;
        cur = mk(0, 0, 1, 0);
        vecs[0] = '{8'hA5, 12'b1101_1010_0101};
        vecs[1] = '{8'h00, 12'b1101_0000_0000};
        vecs[2] = '{8'hFF, 12'b1101_1111_1111};
        vecs[3] = '{8'h3C, 12'b1101_0011_1100};
        vecs[4] = '{8'h81, 12'b1101_1000_0001};

        @(negedge clk);
        @(negedge clk);
        do_reset();
        repeat (2) cycle(1'b0, 8'h00);

        // Single frames from the table
        for (int i = 0; i < 5; i++) begin
            obs_n = 0;
            cycle(1'b1, vecs[i].d);
            repeat (15) cycle(1'b0, 8'h00);
            chk("vec_bits", int'(obs), int'(vecs[i].bits));
            chk("vec_nbits", obs_n, 12);
            chk("vec_frames", int'(frame_cnt), i + 1);
        end

        // tx_valid held high: back-to-back frames
        acc_cyc.delete();
        base = fcnt;
        cycle(1'b1, 8'h00);
        repeat (13) cycle(1'b1, 8'hFF);
        chk("b2b_first", int'(obs), 12'b1101_0000_0000);
        repeat (2) cycle(1'b1, 8'hFF);
        tx_valid = 1'b0;
        repeat (15) cycle(1'b0, 8'h00);
        chk("b2b_second", int'(obs), 12'b1101_1111_1111);
        chk("b2b_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2)
            chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 15);
        chk("b2b_frames", int'(frame_cnt), (base + 2) % 256);

        // Mid-frame data change and valid pulse are ignored
        acc_cyc.delete();
        cycle(1'b1, 8'hA5);
        repeat (6) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h3C);
        repeat (7) cycle(1'b0, 8'h3C);
        chk("mid_bits", int'(obs), 12'b1101_1010_0101);
        repeat (2) cycle(1'b0, 8'h00);
        chk("mid_accepts", acc_cyc.size(), 1);

        // Asynchronous reset during the third data bit
        cycle(1'b1, 8'h20);
        repeat (6) cycle(1'b0, 8'h00);
        chk("pre_rst_out", int'(out), 1);
        chk("pre_rst_frames", int'(frame_cnt), fcnt);
        do_reset();
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hC3);
        chk("fresh_first", int'(out), 1);
        repeat (15) cycle(1'b0, 8'h00);
        chk("fresh_bits", int'(obs), 12'b1101_1100_0011);
        chk("fresh_frames", int'(frame_cnt), 1);

        // Frame counter wrap
        do_reset();
        cycle(1'b0, 8'h00);
        for (int n = 1; n <= 257; n++) begin
            cycle(1'b1, 8'(n));
            repeat (14) cycle(1'b0, 8'h00);
            if (n == 255) chk("wrap_255", int'(frame_cnt), 255);
            if (n == 256) chk("wrap_256", int'(frame_cnt), 0);
            if (n == 257) chk("wrap_257", int'(frame_cnt), 1);
        end

        // Line fed into a 1101 Moore detector
        repeat (4) cycle(1'b0, 8'h00);
        det_cnt = 0;
        det_pos = -1;
        det_base = cyc;
        cycle(1'b1, 8'h00);
        repeat (15) cycle(1'b0, 8'h00);
        chk("det_pulses", det_cnt, 1);
        chk("det_pos", det_pos, 5);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 3) == 0, 8'($urandom));
        repeat (16) cycle(1'b0, 8'h00);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
